// File: rtl/ultrasonido_eco.sv
`timescale 1ns/1ps
// ultrasonido_eco: HC-SR04-style sensor responder (trigger in, echo out) for radar-path loopback.
// Latency: eco rises ECHO_DELAY_US ticks (-1 tick) after an accepted trigger fall, plus 2-3 clk sync/FSM.
// Backpressure: none; triggers outside IDLE are ignored and holdoff waits for trigger to return low.
module ultrasonido_eco #(
   parameter int CLK_DIV       = 50,
   parameter int MIN_TRIG_US   = 10,
   parameter int ECHO_DELAY_US = 20,
   parameter int MAX_ECHO_US   = 30000,
   parameter int HOLDOFF_US    = 60
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        trigger,
   input  logic [15:0] distancia_us,
   output logic        eco,
   output logic        busy,
   output logic        trig_corto,
   output logic [7:0]  disparos
);

   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
   localparam logic [15:0]   MIN_W    = 16'(MIN_TRIG_US);
   localparam logic [15:0]   DLY_W    = 16'(ECHO_DELAY_US);
   localparam logic [15:0]   MAX_W    = 16'(MAX_ECHO_US);
   localparam logic [15:0]   HOLD_W   = 16'(HOLDOFF_US);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_TRIG  = 3'd1;
   localparam logic [2:0] S_DELAY = 3'd2;
   localparam logic [2:0] S_ECHO  = 3'd3;
   localparam logic [2:0] S_HOLD  = 3'd4;

   logic [PW-1:0] pre_q, pre_d;
   logic          tick;
   logic          sync1_q, sync2_q, sync3_q;
   logic          rise, fall;
   logic [2:0]    state_q, state_d;
   logic [15:0]   width_q, width_d;
   logic [15:0]   timer_q, timer_d;
   logic [15:0]   ew_q, ew_d;
   logic [15:0]   timer_inc;
   logic [15:0]   req_w;
   logic          eco_q, eco_d;
   logic          corto_q, corto_d;
   logic [7:0]    disparos_q, disparos_d;

   // Free-running microsecond prescaler; tick marks the last cycle of each period.
   always_comb begin
      tick  = (pre_q == PRE_LAST);
      pre_d = tick ? '0 : pre_q + PW'(1);
   end

   // Edges are taken on the synchronized trigger, against its one-cycle-delayed copy.
   always_comb begin
      rise = sync2_q & ~sync3_q;
      fall = ~sync2_q & sync3_q;
   end

   // Echo width requested by the controller: 0 means "no object", oversize requests clamp.
   always_comb begin
      req_w = ((distancia_us == 16'd0) || (distancia_us > MAX_W)) ? MAX_W : distancia_us;
   end

   // Responder FSM: qualify trigger width, wait sensor latency, emit echo, then hold off.
   always_comb begin
      state_d    = state_q;
      width_d    = width_q;
      timer_d    = timer_q;
      ew_d       = ew_q;
      eco_d      = eco_q;
      corto_d    = 1'b0;
      disparos_d = disparos_q;
      timer_inc  = timer_q + 16'd1;
      case (state_q)
         S_IDLE: begin
            if (enable && rise) begin
               width_d = '0;
               state_d = S_TRIG;
            end
         end
         S_TRIG: begin
            if (!enable) begin
               // Abort quietly: the controller switched us off mid-pulse.
               state_d = S_IDLE;
            end else if (fall) begin
               if (width_q >= MIN_W) begin
                  ew_d       = req_w;
                  timer_d    = '0;
                  disparos_d = disparos_q + 8'd1;
                  state_d    = S_DELAY;
               end else begin
                  corto_d = 1'b1;
                  state_d = S_IDLE;
               end
            end else if (tick && (width_q != 16'hFFFF)) begin
               width_d = width_q + 16'd1;
            end
         end
         S_DELAY: begin
            if (tick) begin
               if (timer_inc == DLY_W) begin
                  eco_d   = 1'b1;
                  timer_d = '0;
                  state_d = S_ECHO;
               end else begin
                  timer_d = timer_inc;
               end
            end
         end
         S_ECHO: begin
            // eco rose on a tick edge and falls on a tick edge: exactly ew_q periods high.
            if (tick) begin
               if (timer_inc == ew_q) begin
                  eco_d   = 1'b0;
                  timer_d = '0;
                  state_d = S_HOLD;
               end else begin
                  timer_d = timer_inc;
               end
            end
         end
         S_HOLD: begin
            if (tick && (timer_q != HOLD_W)) begin
               timer_d = timer_inc;
            end
            // A trigger still high here must drop first, so it is never seen as a new rise.
            if ((timer_q == HOLD_W) && !sync2_q) begin
               timer_d = '0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers, synchronizer and prescaler; reset aborts any transaction at once.
   always_ff @(posedge clk) begin
      if (reset) begin
         pre_q      <= '0;
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         sync3_q    <= 1'b0;
         state_q    <= S_IDLE;
         width_q    <= '0;
         timer_q    <= '0;
         ew_q       <= '0;
         eco_q      <= 1'b0;
         corto_q    <= 1'b0;
         disparos_q <= '0;
      end else begin
         pre_q      <= pre_d;
         sync1_q    <= trigger;
         sync2_q    <= sync1_q;
         sync3_q    <= sync2_q;
         state_q    <= state_d;
         width_q    <= width_d;
         timer_q    <= timer_d;
         ew_q       <= ew_d;
         eco_q      <= eco_d;
         corto_q    <= corto_d;
         disparos_q <= disparos_d;
      end
   end

   assign eco        = eco_q;
   assign busy       = (state_q != S_IDLE);
   assign trig_corto = corto_q;
   assign disparos   = disparos_q;

endmodule

// File: tb/tb_ultrasonido_eco.sv
`timescale 1ns/1ps
// tb_ultrasonido_eco: directed checks of the echo responder with shortened timing parameters.
// Latency: all timing expectations are hand-derived from CLK_DIV, ECHO_DELAY_US and HOLDOFF_US below.
// Backpressure: not applicable; every wait on the DUT is bounded.
module tb_ultrasonido_eco;

   localparam int C  = 4;    // clk per tick
   localparam int MT = 4;    // min trigger ticks
   localparam int D  = 6;    // echo delay ticks
   localparam int MX = 100;  // max echo ticks
   localparam int H  = 8;    // holdoff ticks

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        trigger;
   logic [15:0] distancia_us;
   logic        eco;
   logic        busy;
   logic        trig_corto;
   logic [7:0]  disparos;

   int   n_chk = 0;
   int   n_err = 0;
   int   cnt = 0;
   int   eco_rises = 0;
   int   corto_cnt = 0;
   logic eco_prev = 1'b0;

   ultrasonido_eco #(
      .CLK_DIV(C), .MIN_TRIG_US(MT), .ECHO_DELAY_US(D), .MAX_ECHO_US(MX), .HOLDOFF_US(H)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .trigger(trigger),
      .distancia_us(distancia_us), .eco(eco), .busy(busy),
      .trig_corto(trig_corto), .disparos(disparos)
   );

   always #5 clk = ~clk;

   // Cycle counter: equals the number of the last rising edge when read #1 after it.
   always @(posedge clk) cnt <= cnt + 1;

   // Event monitor on the falling edge: echo rising edges and trig_corto high cycles.
   always @(negedge clk) begin
      if (eco && !eco_prev) eco_rises++;
      if (trig_corto) corto_cnt++;
      eco_prev = eco;
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic trig_pulse(input int hi);
      trigger = 1'b1;
      step(hi);
      trigger = 1'b0;
   endtask

   task automatic wait_eco(input logic lvl, input int lim, input string tag, output int t);
      int n = 0;
      while (eco !== lvl && n < lim) begin
         step(1);
         n++;
      end
      if (eco !== lvl) chk({tag, "_eco_timeout"}, int'(eco), int'(lvl));
      t = cnt;
   endtask

   task automatic wait_busy0(input int lim, input string tag, output int t);
      int n = 0;
      while (busy !== 1'b0 && n < lim) begin
         step(1);
         n++;
      end
      if (busy !== 1'b0) chk({tag, "_busy_timeout"}, int'(busy), 0);
      t = cnt;
   endtask

   // One full transaction with a 6-tick trigger; request and enable are disturbed mid-echo
   // to show the latched width and in-flight completion.
   task automatic echo_txn(input string tag, input int w_cycles);
      int tf, tr, tfl, ti, dl;
      trig_pulse(6 * C);
      tf = cnt;
      wait_eco(1'b1, 100, tag, tr);
      dl = tr - tf;
      chk({tag, "_dly_lo"}, int'(dl >= 4 + (D - 1) * C), 1);
      chk({tag, "_dly_hi"}, int'(dl <= 3 + D * C), 1);
      distancia_us = 16'd3;
      enable = 1'b0;
      wait_eco(1'b0, 1000, tag, tfl);
      chk({tag, "_width"}, tfl - tr, w_cycles);
      wait_busy0(200, tag, ti);
      chk({tag, "_holdoff"}, ti - tfl, H * C + 1);
      enable = 1'b1;
   endtask

   // Continuous controller-style PWM: 6 ticks high, 10-tick period.
   task automatic pwm(input int n_pulses);
      for (int k = 0; k < n_pulses; k++) begin
         trigger = 1'b1;
         step(6 * C);
         trigger = 1'b0;
         step(4 * C);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, r0, d0, t;
      reset = 1'b1;
      enable = 1'b1;
      trigger = 1'b0;
      distancia_us = 16'd20;
      step(3);
      chk("rst_eco", int'(eco), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_corto", int'(trig_corto), 0);
      chk("rst_disparos", int'(disparos), 0);
      reset = 1'b0;
      step(5);

      // Normal transaction: 20-tick echo.
      echo_txn("norm", 20 * C);
      chk("norm_disparos", int'(disparos), 1);

      // Short trigger (2 ticks) is rejected with a single-cycle trig_corto.
      c0 = corto_cnt;
      r0 = eco_rises;
      trig_pulse(2 * C);
      step(20);
      chk("short_corto", corto_cnt - c0, 1);
      chk("short_eco", eco_rises - r0, 0);
      chk("short_disparos", int'(disparos), 1);
      chk("short_busy", int'(busy), 0);

      // Enable dropped while the trigger is high: silent abort.
      trigger = 1'b1;
      step(6);
      chk("trg_busy", int'(busy), 1);
      enable = 1'b0;
      step(2);
      chk("trg_abort", int'(busy), 0);
      trigger = 1'b0;
      step(10);
      chk("trg_no_corto", corto_cnt - c0, 1);
      chk("trg_disparos", int'(disparos), 1);
      enable = 1'b1;
      step(2);

      // Width mapping: no-object, clamps, exact max, minimum.
      distancia_us = 16'd0;     echo_txn("zero", MX * C);
      distancia_us = 16'd40000; echo_txn("big", MX * C);
      distancia_us = 16'd101;   echo_txn("over", MX * C);
      distancia_us = 16'd100;   echo_txn("max", MX * C);
      distancia_us = 16'd1;     echo_txn("one", 1 * C);
      chk("clamp_disparos", int'(disparos), 6);

      // PWM, holdoff ending while trigger low: every third pulse accepted.
      r0 = eco_rises;
      d0 = int'(disparos);
      distancia_us = 16'd7;
      pwm(12);
      wait_busy0(400, "pwm7", t);
      chk("pwm7_echoes", eco_rises - r0, 4);
      chk("pwm7_disparos", int'(disparos) - d0, 4);

      // PWM, holdoff ending while trigger high: must wait for low, every fourth accepted.
      r0 = eco_rises;
      d0 = int'(disparos);
      distancia_us = 16'd11;
      pwm(12);
      wait_busy0(400, "pwm11", t);
      chk("pwm11_echoes", eco_rises - r0, 3);
      chk("pwm11_disparos", int'(disparos) - d0, 3);

      // Reset in the middle of an echo.
      distancia_us = 16'd50;
      trig_pulse(6 * C);
      wait_eco(1'b1, 100, "rst_mid", t);
      step(20);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      chk("rstmid_eco", int'(eco), 0);
      chk("rstmid_busy", int'(busy), 0);
      chk("rstmid_disparos", int'(disparos), 0);
      distancia_us = 16'd20;
      step(5);
      echo_txn("post", 20 * C);
      chk("post_disparos", int'(disparos), 1);

      // Disabled responder ignores valid triggers.
      reset = 1'b1;
      step(2);
      reset = 1'b0;
      enable = 1'b0;
      r0 = eco_rises;
      trig_pulse(6 * C);
      step(60);
      trig_pulse(6 * C);
      step(60);
      chk("dis_echoes", eco_rises - r0, 0);
      chk("dis_disparos", int'(disparos), 0);
      chk("dis_busy", int'(busy), 0);
      enable = 1'b1;
      step(4);

      // 256 accepted transactions wrap the counter.
      distancia_us = 16'd1;
      r0 = eco_rises;
      for (int i = 0; i < 256; i++) begin
         trig_pulse(6 * C);
         wait_busy0(200, "wrap", t);
         if (i == 254) chk("wrap_255", int'(disparos), 255);
      end
      chk("wrap_0", int'(disparos), 0);
      chk("wrap_echoes", eco_rises - r0, 256);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
